ice40up5k_spram_wb: RTL
=======================

# ice40up5k_spram_wb

Wishbone-classic slave wrapping one or two 32-bit banks of iCE40UP5K SB_SPRAM256KA primitives (each bank is two 16-bit SPRAMs, 16K words = 64 kB). It is the parametrised successor of the fixed 128 kB SPRAM glue. It adds bus handshaking, registered read-data steering and optional per-bank automatic sleep with wake-up sequencing. It sits on the SoC data bus as main RAM.

## Interface
- BANKS, 2: number of 32-bit banks; legal values 1 or 2, any other value is an elaboration error.
- ADDR_W, 14 + $clog2(BANKS): word-address width; derived, not overridden.
- IDLE_CYCLES, 256: idle clocks before a bank enters sleep (only with SPRAM_SLEEP_EN); ≥1.
- WAKE_CYCLES, 3: clocks SLEEP must be low before a woken bank is accessed; ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_cyc  in  1  bus cycle valid.
- wb_stb  in  1  strobe.
- wb_we  in  1  1 = write.
- wb_sel  in  4  byte enables; bit n covers dat[8n+7:8n].
- wb_adr  in  ADDR_W  word address; top bit selects bank when BANKS = 2.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid only while wb_ack = 1.
- wb_ack  out  1  single-cycle acknowledge.
- sleep_o  out  BANKS  1 = bank currently in SLEEP.

## Operation
- Request = wb_cyc & wb_stb & !wb_ack. A request is never accepted in the cycle wb_ack is high, so there is one transfer per two clocks minimum.
- FSM states: IDLE, WAKE, ACCESS.
- IDLE behaviour:
  - If a request targets an awake bank, drive that bank's SPRAMs directly from the bus (CHIPSELECT = 1, ADDRESS = wb_adr[13:0], WREN = wb_we & |wb_sel, MASKWREN = {sel[1],sel[1],sel[0],sel[0]} low half, {sel[3],sel[3],sel[2],sel[2]} high half). Register the bank index and set wb_ack next cycle. Stay in IDLE.
  - If the target bank is asleep, clear its SLEEP, load the wake counter with WAKE_CYCLES and go to WAKE. SPRAMs are not selected in this cycle.
- WAKE: decrement the counter. At 0, go to ACCESS. The master holds the bus signals.
- ACCESS: drive the SPRAM ports from the bus as in IDLE, set wb_ack next cycle, return to IDLE.
- If wb_cyc drops in WAKE or ACCESS, return to IDLE with no SPRAM access and no ack. The bank stays awake and its idle counter is cleared.
- Read data: wb_dat_o = {hi,lo} DATAOUT of the bank registered at the access edge. When wb_ack = 0, wb_dat_o is 0.
- Write with wb_sel = 0: acked, no array change.
- Unselected banks have CHIPSELECT = 0. STANDBY is tied 0 and POWEROFF is tied 1 on all SPRAMs.
- Reset values: wb_ack 0, wb_dat_o 0, FSM IDLE, all banks awake (sleep_o 0), all counters 0.
- Reset during WAKE or ACCESS aborts the transfer with no ack. The SPRAM array contents are preserved.

## Timing
- Awake bank: request sampled at edge E0 → wb_ack = 1 between E0 and E1. Latency 1 clock for both read and write.
- Sleeping bank: request at E0 → WAKE for WAKE_CYCLES clocks → ACCESS for one clock → ack. Total latency WAKE_CYCLES + 2 clocks (5 at default).
- wb_ack is high for exactly one clock per accepted transfer.
- sleep_o for a bank falls at the same edge its SLEEP input falls, and rises at the edge its SLEEP input rises.

## Configuration
- SPRAM_SLEEP_EN defined:
  - Each bank has a saturating idle counter. It clears on any access to that bank (including a WAKE entry) and increments otherwise.
  - When the counter reaches IDLE_CYCLES, the bank's SLEEP is set to 1.
  - A request and the sleep threshold in the same cycle: the request wins; the bank stays awake and is accessed with 1-clock latency.
- SPRAM_SLEEP_EN undefined: SLEEP is tied 0, sleep_o is constant 0, no idle counters exist, WAKE is never entered, and every transfer has 1-clock latency.

## Test plan
- Write 0xDEADBEEF at 0x0010 with sel = 0xF, then read 0x0010 → each wb_ack one clock after the request, read returns 0xDEADBEEF.
- Write 0x11223344 then write 0xAABBCCDD at 0x0020 with sel = 0x5, read 0x0020 → 0x11BB33DD.
- BANKS = 2: write 0x1 to 0x0005 and 0x2 to 0x4005, read both → 0x1 and 0x2; a bank-0 read does not select bank 1.
- SPRAM_SLEEP_EN, IDLE_CYCLES = 8: stay idle 8 clocks → sleep_o = 2'b11. Read 0x0010 → sleep_o[0] falls immediately, ack after WAKE_CYCLES + 2 = 5 clocks, data intact.
- Drop wb_cyc during WAKE → no ack, FSM back to IDLE; the next request to the same bank acks in 1 clock.
- Assert rst during ACCESS → no ack, wb_dat_o = 0, sleep_o = 0; previously written data still reads back correctly.

Source files
------------

// File: rtl/ice40up5k_spram_wb.sv
// Wishbone-classic slave over one or two 32-bit SB_SPRAM256KA banks (64 kB each).
// Optional per-bank idle sleep with wake-up sequencing when SPRAM_SLEEP_EN is defined.
module ice40up5k_spram_wb #(
  parameter int BANKS       = 2,
  parameter int ADDR_W      = 14 + $clog2(BANKS),
  parameter int IDLE_CYCLES = 256,
  parameter int WAKE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [3:0]        wb_sel,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack,
  output logic [BANKS-1:0]  sleep_o
);

  localparam int WW = $clog2(WAKE_CYCLES + 1);

  if (BANKS != 1 && BANKS != 2) begin : g_bad_banks
    $error("BANKS must be 1 or 2");
  end
  if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || ADDR_W != 14 + $clog2(BANKS)) begin : g_bad_cfg
    $error("illegal IDLE_CYCLES / WAKE_CYCLES / ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, WAKE, ACCESS} state_t;

  state_t             state;
  logic [WW-1:0]      wake_cnt;
  logic [BANKS-1:0]   sleep_q;
  logic [BANKS-1:0]   req_mask;
  logic [BANKS-1:0]   acc_mask;
  logic [BANKS-1:0]   cs;
  logic               bank_q;
  logic               req;
  logic               req_bank;
  logic               acc_bank;
  logic               tgt_asleep;
  logic               go;
  logic               wren;
  logic [31:0]        dout [BANKS];

  assign req      = wb_cyc & wb_stb & ~wb_ack;
  assign req_bank = (BANKS == 2) ? wb_adr[ADDR_W-1] : 1'b0;
  // WAKE/ACCESS stick to the bank latched on WAKE entry, so a dropped cycle still clears the right idle counter.
  assign acc_bank = (state == IDLE) ? req_bank : bank_q;
  assign wren     = wb_we & (|wb_sel);
  assign sleep_o  = sleep_q;

  always_comb begin
    req_mask = '0;
    acc_mask = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      req_mask[b] = (req_bank == 1'(b));
      acc_mask[b] = (acc_bank == 1'(b));
    end
  end

  assign tgt_asleep = |(sleep_q & req_mask);
  assign go         = ~rst & req & (((state == IDLE) & ~tgt_asleep) | (state == ACCESS));
  assign cs         = go ? acc_mask : '0;

`ifdef SPRAM_SLEEP_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic [IW-1:0]    idle_cnt [BANKS];
  logic [BANKS-1:0] touch;

  always_comb begin
    touch = '0;
    if (state == IDLE) begin
      if (req) touch = req_mask;
    end else begin
      touch = acc_mask;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wb_ack   <= 1'b0;
      bank_q   <= 1'b0;
      wake_cnt <= '0;
      sleep_q  <= '0;
`ifdef SPRAM_SLEEP_EN
      for (int unsigned b = 0; b < BANKS; b++) idle_cnt[b] <= '0;
`endif
    end else begin
      wb_ack <= go;
      case (state)
        IDLE: begin
          if (req && tgt_asleep) begin
            sleep_q  <= sleep_q & ~req_mask;
            bank_q   <= req_bank;
            wake_cnt <= WW'(WAKE_CYCLES);
            state    <= WAKE;
          end else if (go) begin
            bank_q <= req_bank;
          end
        end
        WAKE: begin
          if (!wb_cyc) begin
            state <= IDLE;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
            if (wake_cnt <= WW'(1)) state <= ACCESS;
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef SPRAM_SLEEP_EN
      // A touched bank never crosses the threshold, so a same-cycle request beats sleep entry.
      for (int unsigned b = 0; b < BANKS; b++) begin
        if (touch[b]) begin
          idle_cnt[b] <= '0;
        end else if (idle_cnt[b] != IW'(IDLE_CYCLES)) begin
          idle_cnt[b] <= idle_cnt[b] + 1'b1;
          if (idle_cnt[b] == IW'(IDLE_CYCLES - 1)) sleep_q[b] <= 1'b1;
        end
      end
`endif
    end
  end

  always_comb begin
    wb_dat_o = '0;
    if (wb_ack) wb_dat_o = (BANKS == 2 && bank_q) ? dout[BANKS-1] : dout[0];
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
`ifdef SYNTHESIS
    logic [15:0] lo;
    logic [15:0] hi;

    SB_SPRAM256KA u_lo (
      .ADDRESS   (wb_adr[13:0]),
      .DATAIN    (wb_dat_i[15:0]),
      .MASKWREN  ({wb_sel[1], wb_sel[1], wb_sel[0], wb_sel[0]}),
      .WREN      (wren),
      .CHIPSELECT(cs[b]),
      .CLOCK     (clk),
      .STANDBY   (1'b0),
      .SLEEP     (sleep_q[b]),
      .POWEROFF  (1'b1),
      .DATAOUT   (lo)
    );

    SB_SPRAM256KA u_hi (
      .ADDRESS   (wb_adr[13:0]),
      .DATAIN    (wb_dat_i[31:16]),
      .MASKWREN  ({wb_sel[3], wb_sel[3], wb_sel[2], wb_sel[2]}),
      .WREN      (wren),
      .CHIPSELECT(cs[b]),
      .CLOCK     (clk),
      .STANDBY   (1'b0),
      .SLEEP     (sleep_q[b]),
      .POWEROFF  (1'b1),
      .DATAOUT   (hi)
    );

    assign dout[b] = {hi, lo};
`else
    // Behavioural stand-in for the SPRAM pair: synchronous read, byte-masked write.
    logic [31:0] mem [16384];
    logic [31:0] q;

    always_ff @(posedge clk) begin
      if (cs[b]) begin
        if (wren) begin
          for (int unsigned n = 0; n < 4; n++)
            if (wb_sel[n]) mem[wb_adr[13:0]][8*n +: 8] <= wb_dat_i[8*n +: 8];
        end else begin
          q <= mem[wb_adr[13:0]];
        end
      end
    end

    assign dout[b] = q;
`endif
  end

endmodule
